bht_update_ctrl: RTL and testbench

- Schedules write-back of resolved branch outcomes into the 2-bit-counter branch history table (BHT).
- Sits between execute-stage branch resolution and the BHT's single write port. Buffers resolutions in a small FIFO and retires one per cycle as a read-modify-write.
- Also sequences a full-table clear, used on context switch or predictor flush.
- The fetch-side prediction read is not routed through this block.

---
 rtl/bp_pkg.sv | 31 +++
 rtl/bht_upd_fifo.sv | 69 ++++++
 rtl/bht_update_ctrl.sv | 152 +++++++++++++++
 tb/tb_bht_update_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter encoding, its saturating update,
// and the BHT write-back controller state encoding.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } state_t;

    localparam state_t BHT_RESET_STATE = WNT;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } ctrl_state_t;

    function automatic state_t sat_next(input state_t s, input logic taken);
        state_t r;
        r = s;
        if (taken) begin
            if (s != ST) r = state_t'(s + 2'd1);
        end else begin
            if (s != SNT) r = state_t'(s - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Resolution buffer holding {index, taken}; flush empties it in one cycle.
module bht_upd_fifo #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [INDEX_BITS-1:0]         push_index,
    input  logic                          push_taken,
    input  logic                          pop,
    input  logic                          flush,
    output logic [INDEX_BITS-1:0]         head_index,
    output logic                          head_taken,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [INDEX_BITS:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= {push_index, push_taken};
    end

    always_comb begin
        {head_index, head_taken} = mem_q[rd_ptr_q];
        full  = (level_q == FULL_LVL);
        empty = (level_q == '0);
        level = level_q;
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT write-back scheduler: buffers branch resolutions, retires one read-modify-write
// per cycle, and sequences full-table clears. Optional stats: BHT_UPD_STATS_EN.
module bht_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          res_valid,
    input  logic [31:0]                   res_pc,
    input  logic                          res_taken,
    input  logic                          clear_req,
    output logic                          clear_busy,
    output logic [INDEX_BITS-1:0]         tbl_rd_index,
    input  logic [1:0]                    tbl_rd_state,
    output logic                          tbl_wr_en,
    output logic [INDEX_BITS-1:0]         tbl_wr_index,
    output logic [1:0]                    tbl_wr_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_CNT_W-1:0]         drop_cnt
`ifdef BHT_UPD_STATS_EN
    ,
    output logic [31:0]                   upd_cnt,
    output logic [31:0]                   flip_cnt
`endif
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    ctrl_state_t           state_q, state_d;
    logic [INDEX_BITS-1:0] clr_idx_q, clr_idx_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [INDEX_BITS-1:0] head_index;
    logic                  head_taken, fifo_full, fifo_empty;
    logic [LVL_W-1:0]      level;
    logic                  pop, push, discard;

    // A clear request wins over the drain in its own cycle, so no write slips in ahead of it.
    always_comb begin
        pop = (state_q == DRAIN) && !fifo_empty && !clear_req;
    end

    always_comb begin
        discard    = (state_q == CLEAR) || clear_req;
        push       = res_valid && !discard && (!fifo_full || pop);
        drop_cnt_d = drop_cnt_q;
        if (res_valid && !discard && !push && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + 1'b1;
    end

    bht_upd_fifo #(
        .INDEX_BITS(INDEX_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_index (res_pc[INDEX_BITS+1:2]),
        .push_taken (res_taken),
        .pop        (pop),
        .flush      (clear_req),
        .head_index (head_index),
        .head_taken (head_taken),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (level)
    );

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            IDLE:  if (!fifo_empty) state_d = DRAIN;
            DRAIN: if (fifo_empty || (pop && level == LVL_W'(1) && !push)) state_d = IDLE;
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == '1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_req) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            clr_idx_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        tbl_rd_index = '0;
        tbl_wr_en    = 1'b0;
        tbl_wr_index = '0;
        tbl_wr_state = SNT;
        if (state_q == CLEAR) begin
            tbl_wr_en    = 1'b1;
            tbl_wr_index = clr_idx_q;
            tbl_wr_state = BHT_RESET_STATE;
        end else if (pop) begin
            tbl_rd_index = head_index;
            tbl_wr_en    = 1'b1;
            tbl_wr_index = head_index;
            tbl_wr_state = sat_next(state_t'(tbl_rd_state), head_taken);
        end
        clear_busy = (state_q == CLEAR);
        fifo_level = level;
        drop_cnt   = drop_cnt_q;
    end

`ifdef BHT_UPD_STATS_EN
    logic [31:0] upd_cnt_q, upd_cnt_d, flip_cnt_q, flip_cnt_d;

    always_comb begin
        upd_cnt_d  = upd_cnt_q;
        flip_cnt_d = flip_cnt_q;
        if (clear_req) begin
            upd_cnt_d  = '0;
            flip_cnt_d = '0;
        end else if (pop) begin
            upd_cnt_d = upd_cnt_q + 32'd1;
            if (tbl_wr_state[1] != tbl_rd_state[1]) flip_cnt_d = flip_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_cnt_q  <= '0;
            flip_cnt_q <= '0;
        end else begin
            upd_cnt_q  <= upd_cnt_d;
            flip_cnt_q <= flip_cnt_d;
        end
    end

    always_comb begin
        upd_cnt  = upd_cnt_q;
        flip_cnt = flip_cnt_q;
    end
`endif

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl: expected table writes queued by stimulus,
// checked by a negedge monitor against a behavioural 16-entry BHT.
module tb_bht_update_ctrl;
    typedef struct packed {
        logic [3:0] idx;
        logic [1:0] st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic        clear_req;
    logic        clear_busy;
    logic [3:0]  tbl_rd_index;
    logic [1:0]  tbl_rd_state;
    logic        tbl_wr_en;
    logic [3:0]  tbl_wr_index;
    logic [1:0]  tbl_wr_state;
    logic [2:0]  fifo_level;
    logic [15:0] drop_cnt;
`ifdef BHT_UPD_STATS_EN
    logic [31:0] upd_cnt, flip_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [1:0] tbl [16];
    logic tbl_init;
    int   busy_cycles;

    bht_update_ctrl #(
        .INDEX_BITS(4),
        .FIFO_DEPTH(4),
        .DROP_CNT_W(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .res_valid    (res_valid),
        .res_pc       (res_pc),
        .res_taken    (res_taken),
        .clear_req    (clear_req),
        .clear_busy   (clear_busy),
        .tbl_rd_index (tbl_rd_index),
        .tbl_rd_state (tbl_rd_state),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_wr_index (tbl_wr_index),
        .tbl_wr_state (tbl_wr_state),
        .fifo_level   (fifo_level),
        .drop_cnt     (drop_cnt)
`ifdef BHT_UPD_STATS_EN
        ,
        .upd_cnt      (upd_cnt),
        .flip_cnt     (flip_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tbl_init) begin
            for (int i = 0; i < 16; i++) tbl[i] <= 2'b01;
        end else if (tbl_wr_en) begin
            tbl[tbl_wr_index] <= tbl_wr_state;
        end
    end
    assign tbl_rd_state = tbl[tbl_rd_index];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && tbl_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got idx %0d state %b expected no write",
                         tbl_wr_index, tbl_wr_state);
            end else begin
                e = exp_q.pop_front();
                chk("wr_index", {28'd0, tbl_wr_index}, {28'd0, e.idx});
                chk("wr_state", {30'd0, tbl_wr_state}, {30'd0, e.st});
            end
        end
    end

    task automatic res(input logic [31:0] pc, input logic t);
        res_valid = 1'b1;
        res_pc    = pc;
        res_taken = t;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic expw(input logic [3:0] idx, input logic [1:0] st);
        exp_q.push_back({idx, st});
    endtask

    task automatic wait_q(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic exp_clear();
        for (int i = 0; i < 16; i++) expw(4'(i), 2'b01);
    endtask

    initial begin
        rst = 1'b0; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0;
        clear_req = 1'b0; tbl_init = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_wr_en", tbl_wr_en, 0);
        chk("rst_wr_index", tbl_wr_index, 0);
        chk("rst_wr_state", tbl_wr_state, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_cnt, 0);
        tbl_init = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // single resolution, idx 4 taken: 01 -> 10, one cycle of IDLE then write
        expw(4'd4, 2'b10);
        res(32'h10, 1'b1);
        @(negedge clk); chk("lat_idle_wr_en", tbl_wr_en, 0);
        @(negedge clk); chk("lat_drain_wr_en", tbl_wr_en, 1);
        wait_q("t1_drain");

        // same index back-to-back: 01 -> 10 -> 11 -> 11
        expw(4'd8, 2'b10); expw(4'd8, 2'b11); expw(4'd8, 2'b11);
        res(32'h20, 1'b1); res(32'h20, 1'b1); res(32'h20, 1'b1);
        wait_q("t2_drain");

        // six consecutive resolutions while draining
        expw(4'd1, 2'b10); expw(4'd2, 2'b00); expw(4'd1, 2'b11);
        expw(4'd3, 2'b00); expw(4'd2, 2'b00); expw(4'd1, 2'b11);
        res(32'h04, 1'b1); res(32'h08, 1'b0); res(32'h04, 1'b1);
        res(32'h0C, 1'b0); res(32'h08, 1'b0); res(32'h04, 1'b1);
        wait_q("t3_drain");
        chk("t3_drop", drop_cnt, 0);

        // resolutions during CLEAR are discarded without counting as drops
        exp_clear();
        clear_req = 1'b1; res_valid = 1'b1; res_pc = 32'h14; res_taken = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        res_valid = 1'b0;
        chk("t3_clear_drop", drop_cnt, 0);
        chk("t3_clear_level", fifo_level, 0);
        chk("t3_clear_busy", clear_busy, 1);
        wait_q("t3_clear");
        chk("t3_clear_done", clear_busy, 0);

        // drain held off: 5 pushes into a 4-deep FIFO
        force dut.pop = 1'b0;
        res(32'h14, 1'b1); res(32'h18, 1'b1); res(32'h1C, 1'b0);
        res(32'h14, 1'b1); res(32'h24, 1'b1);
        chk("t4_drop", drop_cnt, 1);
        chk("t4_level", fifo_level, 4);
        expw(4'd5, 2'b10); expw(4'd6, 2'b10); expw(4'd7, 2'b00); expw(4'd5, 2'b11);
        release dut.pop;
        wait_q("t4_drain");

        // clear with 3 entries queued
        force dut.pop = 1'b0;
        res(32'h28, 1'b1); res(32'h2C, 1'b0); res(32'h30, 1'b1);
        chk("t5_level_pre", fifo_level, 3);
        exp_clear();
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        release dut.pop;
        chk("t5_level_flush", fifo_level, 0);
        busy_cycles = 0;
        for (int n = 0; n < 40; n++) begin
            if (clear_busy) busy_cycles++;
            @(posedge clk); #1;
        end
        chk("t5_busy_cycles", busy_cycles, 16);
        chk("t5_writes", exp_q.size(), 0);

        // asynchronous reset in the middle of a drain
        expw(4'd13, 2'b10); expw(4'd14, 2'b00);
        res(32'h34, 1'b1); res(32'h38, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_async_wr_en", tbl_wr_en, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_level", fifo_level, 0);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_busy", clear_busy, 0);
        chk("t6_wr_en", tbl_wr_en, 0);

        @(posedge clk); #1;
        expw(4'd15, 2'b00);
        res(32'h3C, 1'b0);
        wait_q("t7_drain");
        chk("t7_drop", drop_cnt, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
